// File: rtl/fht_pkg.sv
// -----------------------------------------------------------------------------
// fht_pkg
// Shared definitions for the FHT datapath: bank count, point-index width,
// unloader FSM state encoding and the bit-reverse helper that is also used by
// the coefficient address logic.
// -----------------------------------------------------------------------------
package fht_pkg;

   localparam int unsigned N_BANK = 4;

   // Point index covers bank (2 bits) plus bank address.
   function automatic int unsigned idx_width(input int unsigned a_bit);
      return a_bit + 2;
   endfunction

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRead  = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } unload_state_e;

   // Reverse the low 'width' bits of val; bits above width come back as 0.
   function automatic logic [31:0] bit_rev(input logic [31:0] val, input int unsigned width);
      logic [31:0] res;
      res = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < int'(width)) res[i] = val[int'(width) - 1 - i];
      end
      return res;
   endfunction

endpackage

// File: rtl/fht_unload_fifo.sv
// -----------------------------------------------------------------------------
// fht_unload_fifo
// Synchronous FIFO holding {index, data} words between the bank read pipe and
// the downstream valid/ready port. Read data is the head entry (show-ahead).
//
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset
//   flush_i   synchronous empty (takes priority over push/pop)
//   push_i    write wdata_i at the tail
//   wdata_i   entry to write
//   pop_i     drop the head entry (caller guarantees non-empty)
//   rdata_o   head entry
//   empty_o   FIFO holds no entries
//   count_o   number of entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module fht_unload_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 42,
   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q;

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + PW'(1);
         if (pop_i)  rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_q];
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/fht_unloader.sv
// -----------------------------------------------------------------------------
// fht_unloader
// Reads the N = 4*2^A_BIT result points out of the four FHT RAM banks after a
// transform and streams them on a valid/ready port. Reads are credit-gated so
// that every issued read has a guaranteed FIFO slot when it returns.
//
// Build option: define FHT_UNLOAD_BITREV_EN to emit points in bit-reversed
// index order (oINDEX = rev(k)); otherwise natural order.
//
// Ports:
//   iCLK, iRESET         clock, asynchronous active-high reset
//   iFHT_RDY             banks hold a finished result; falling mid-unload aborts
//   iSOURCE_DATA         bank set holding the result, sampled at iUNLOAD
//   iUNLOAD              start pulse (honoured only in idle with iFHT_RDY)
//   oADDR_RD/oRD_EN      bank read address / strobe, oRD_SET bank-set select
//   iDATA_0..iDATA_3     bank read data, RD_LAT clocks after the read
//   oDATA/oINDEX         point and its index, oVALID/iREADY handshake
//   oLAST                with oVALID on the final point
//   oBUSY/oDONE/oABORT   status: running, one-cycle completion, sticky abort
// -----------------------------------------------------------------------------
module fht_unloader
   import fht_pkg::*;
#(
   parameter int unsigned A_BIT      = 8,
   parameter int unsigned D_BIT      = 32,
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned IW        = idx_width(A_BIT)
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iFHT_RDY,
   input  logic             iSOURCE_DATA,
   input  logic             iUNLOAD,
   output logic [A_BIT-1:0] oADDR_RD,
   output logic             oRD_SET,
   output logic             oRD_EN,
   input  logic [D_BIT-1:0] iDATA_0,
   input  logic [D_BIT-1:0] iDATA_1,
   input  logic [D_BIT-1:0] iDATA_2,
   input  logic [D_BIT-1:0] iDATA_3,
   output logic [D_BIT-1:0] oDATA,
   output logic [IW-1:0]    oINDEX,
   output logic             oVALID,
   input  logic             iREADY,
   output logic             oLAST,
   output logic             oBUSY,
   output logic             oDONE,
   output logic             oABORT
);

   localparam int unsigned BankW  = $clog2(N_BANK);
   localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);
   localparam logic [IW-1:0] LastK  = {IW{1'b1}};

   unload_state_e state_q, state_d;
   logic [IW-1:0] k_q, k_d;
   logic          rd_set_q, rd_set_d;
   logic          abort_q, abort_d;

   logic [RD_LAT-1:0] pipe_vld_q;
   logic [IW-1:0]     pipe_pt_q [RD_LAT];

   logic [IW-1:0]     pt;
   logic              issue, flush, pop, credit_ok;
   logic [CntW-1:0]   fifo_cnt, inflight;
   logic              fifo_empty;
   logic [D_BIT+IW-1:0] fifo_wdata, fifo_rdata;
   logic [D_BIT-1:0]  ret_data;
   logic [IW-1:0]     ret_pt, head_idx;
   logic              head_last;

   // Point read at step k; bit-reversal also reverses the bank/address mapping.
`ifdef FHT_UNLOAD_BITREV_EN
   assign pt = IW'(bit_rev(32'(k_q), IW));
`else
   assign pt = k_q;
`endif

   // Reads still travelling through the RAM latency pipe.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(RD_LAT); i++) inflight = inflight + CntW'(pipe_vld_q[i]);
   end

   // The word returning this cycle is also counted as inflight until it lands.
   assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, inflight}) < DepthC;

   assign pop       = ~fifo_empty & iREADY;
   assign head_idx  = fifo_rdata[D_BIT +: IW];
   // rev(N-1) == N-1, so the final emitted point is index N-1 in either order.
   assign head_last = ~fifo_empty & (head_idx == LastK);

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      rd_set_d = rd_set_q;
      abort_d  = abort_q;
      issue    = 1'b0;
      flush    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (iUNLOAD && iFHT_RDY) begin
               state_d  = StRead;
               k_d      = '0;
               rd_set_d = iSOURCE_DATA;
               abort_d  = 1'b0;
            end
         end
         StRead: begin
            if (!iFHT_RDY) begin
               state_d = StIdle;
               flush   = 1'b1;
               abort_d = 1'b1;
            end else if (credit_ok) begin
               issue = 1'b1;
               if (k_q == LastK) state_d = StDrain;
               else              k_d     = k_q + IW'(1);
            end
         end
         StDrain: begin
            if (!iFHT_RDY) begin
               state_d = StIdle;
               flush   = 1'b1;
               abort_d = 1'b1;
            end else if (pop && head_last) begin
               // Last point is the only entry left, so pipe and FIFO are now empty.
               state_d = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state_q  <= StIdle;
         k_q      <= '0;
         rd_set_q <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         rd_set_q <= rd_set_d;
         abort_q  <= abort_d;
      end
   end

   // Read pipe: carries the point index alongside each read for RD_LAT clocks.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         pipe_vld_q <= '0;
         for (int i = 0; i < int'(RD_LAT); i++) pipe_pt_q[i] <= '0;
      end else begin
         pipe_vld_q[0] <= issue & ~flush;
         pipe_pt_q[0]  <= pt;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1] & ~flush;
            pipe_pt_q[i]  <= pipe_pt_q[i-1];
         end
      end
   end

   assign ret_pt = pipe_pt_q[RD_LAT-1];

   always_comb begin
      ret_data = iDATA_0;
      unique case (ret_pt[BankW-1:0])
         2'd0:    ret_data = iDATA_0;
         2'd1:    ret_data = iDATA_1;
         2'd2:    ret_data = iDATA_2;
         default: ret_data = iDATA_3;
      endcase
   end

   assign fifo_wdata = {ret_pt, ret_data};

   fht_unload_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (D_BIT + IW)
   ) u_fifo (
      .clk_i   (iCLK),
      .rst_i   (iRESET),
      .flush_i (flush),
      .push_i  (pipe_vld_q[RD_LAT-1]),
      .wdata_i (fifo_wdata),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   assign oRD_EN   = issue;
   assign oADDR_RD = issue ? pt[IW-1:BankW] : '0;
   assign oRD_SET  = rd_set_q;
   assign oVALID   = ~fifo_empty;
   assign oDATA    = fifo_empty ? '0 : fifo_rdata[D_BIT-1:0];
   assign oINDEX   = fifo_empty ? '0 : head_idx;
   assign oLAST    = head_last;
   assign oBUSY    = (state_q == StRead) || (state_q == StDrain);
   assign oDONE    = (state_q == StDone);
   assign oABORT   = abort_q;

endmodule

// File: tb/tb_fht_unloader.sv
// Scoreboard bench for fht_unloader: a bank RAM model feeds the DUT, the
// stimulus process queues the expected point stream at each unload, and a
// negedge monitor pops and compares every accepted point.
module tb_fht_unloader;

   localparam int A_BIT = 8;
   localparam int D_BIT = 32;
   localparam int RD_LAT = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int IW = A_BIT + 2;
   localparam int N = 4 << A_BIT;

   logic             iCLK = 1'b0;
   logic             iRESET, iFHT_RDY, iSOURCE_DATA, iUNLOAD, iREADY;
   logic [A_BIT-1:0] oADDR_RD;
   logic             oRD_SET, oRD_EN, oVALID, oLAST, oBUSY, oDONE, oABORT;
   logic [D_BIT-1:0] iDATA_0, iDATA_1, iDATA_2, iDATA_3, oDATA;
   logic [IW-1:0]    oINDEX;

   fht_unloader #(
      .A_BIT      (A_BIT),
      .D_BIT      (D_BIT),
      .RD_LAT     (RD_LAT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .iCLK         (iCLK),
      .iRESET       (iRESET),
      .iFHT_RDY     (iFHT_RDY),
      .iSOURCE_DATA (iSOURCE_DATA),
      .iUNLOAD      (iUNLOAD),
      .oADDR_RD     (oADDR_RD),
      .oRD_SET      (oRD_SET),
      .oRD_EN       (oRD_EN),
      .iDATA_0      (iDATA_0),
      .iDATA_1      (iDATA_1),
      .iDATA_2      (iDATA_2),
      .iDATA_3      (iDATA_3),
      .oDATA        (oDATA),
      .oINDEX       (oINDEX),
      .oVALID       (oVALID),
      .iREADY       (iREADY),
      .oLAST        (oLAST),
      .oBUSY        (oBUSY),
      .oDONE        (oDONE),
      .oABORT       (oABORT)
   );

   always #5 iCLK = ~iCLK;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- bank RAM model: set A words are scrambled, set B = 4a+b
   function automatic logic [31:0] ram_word(input logic set, input int b,
                                            input logic [A_BIT-1:0] a);
      logic [31:0] v;
      v = 32'(a) * 4 + 32'(b);
      return set ? v : (v ^ 32'h5A5A_0000);
   endfunction

   logic             s_en, s_set;
   logic [A_BIT-1:0] s_addr;
   logic             rp_set  [RD_LAT];
   logic [A_BIT-1:0] rp_addr [RD_LAT];

   always @(negedge iCLK) begin
      s_en   = oRD_EN;
      s_set  = oRD_SET;
      s_addr = oADDR_RD;
   end

   always @(posedge iCLK) begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
         rp_set[i]  <= rp_set[i-1];
         rp_addr[i] <= rp_addr[i-1];
      end
      rp_set[0]  <= s_en ? s_set : 1'b0;
      rp_addr[0] <= s_en ? s_addr : '0;
   end

   assign iDATA_0 = ram_word(rp_set[RD_LAT-1], 0, rp_addr[RD_LAT-1]);
   assign iDATA_1 = ram_word(rp_set[RD_LAT-1], 1, rp_addr[RD_LAT-1]);
   assign iDATA_2 = ram_word(rp_set[RD_LAT-1], 2, rp_addr[RD_LAT-1]);
   assign iDATA_3 = ram_word(rp_set[RD_LAT-1], 3, rp_addr[RD_LAT-1]);

   // ---------------- reference model and scoreboard
   typedef struct packed {
      logic [IW-1:0] idx;
      logic [31:0]   data;
      logic          last;
   } exp_t;
   exp_t exp_q[$];

   function automatic int rev_idx(input int v);
      int r;
      r = 0;
      for (int i = 0; i < IW; i++) if ((v >> i) & 1) r = r | (1 << (IW - 1 - i));
      return r;
   endfunction

   int cyc = 0;
   always @(posedge iCLK) cyc++;

   int epoch = 0;
   int seen_epoch = 0;
   int issued, popped, acc_cnt, credit_viol = 0, rden_cnt = 0, done_cnt = 0;
   int first_valid_cyc, first_acc_cyc, last_acc_cyc, done_cyc = 0, unload_cyc = 0;
   logic held = 1'b0, prev_done = 1'b0;
   logic [D_BIT-1:0] held_data;
   logic [IW-1:0] held_idx;
   int ready_mode = 0;

   always @(negedge iCLK) begin
      exp_t e;
      if (epoch != seen_epoch) begin
         seen_epoch = epoch;
         issued = 0; popped = 0; acc_cnt = 0;
         first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
         held = 1'b0;
      end
      if (!iRESET) begin
         if (oRD_EN && (issued - popped) >= FIFO_DEPTH) credit_viol++;
         if (oRD_EN) begin
            issued++;
            rden_cnt++;
         end
         if (oVALID && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (held) begin
            chk("hold_valid", oVALID, 1);
            chk("hold_data", oDATA, held_data);
            chk("hold_index", oINDEX, held_idx);
         end
         if (oVALID && iREADY) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra_point: got index %0d expected no point", oINDEX);
            end else begin
               e = exp_q.pop_front();
               chk("point_index", oINDEX, e.idx);
               chk("point_data", oDATA, e.data);
               chk("point_last", oLAST, e.last);
            end
            popped++;
            acc_cnt++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
         end
         held      = oVALID && !iREADY;
         held_data = oDATA;
         held_idx  = oINDEX;
         if (oDONE && prev_done) chk("done_one_cycle", {oDONE, prev_done}, 2'b01);
         if (oDONE) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_done = oDONE;
      end
   end

   // Downstream ready: always 1, or high on ~30% of cycles.
   initial begin
      iREADY = 1'b0;
      forever begin
         @(posedge iCLK);
         #1;
         iREADY = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
      end
   end

   // ---------------- stimulus
   task automatic do_unload(input logic set);
      exp_t e;
      for (int s = 0; s < N; s++) begin
         int p;
`ifdef FHT_UNLOAD_BITREV_EN
         p = rev_idx(s);
`else
         p = s;
`endif
         e.idx  = IW'(p);
         e.data = set ? 32'(p) : (32'(p) ^ 32'h5A5A_0000);
         e.last = (s == N - 1);
         exp_q.push_back(e);
      end
      epoch++;
      iSOURCE_DATA = set;
      iUNLOAD = 1'b1;
      @(posedge iCLK);
      #1;
      unload_cyc = cyc;
      iUNLOAD = 1'b0;
   endtask

   task automatic wait_done(input int budget, input int d0);
      int n;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         @(posedge iCLK);
         #1;
         n++;
      end
      chk("done_seen", done_cnt - d0, 1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_addr"}, oADDR_RD, 0);
      chk({tag, "_rdset"}, oRD_SET, 0);
      chk({tag, "_rden"}, oRD_EN, 0);
      chk({tag, "_data"}, oDATA, 0);
      chk({tag, "_index"}, oINDEX, 0);
      chk({tag, "_valid"}, oVALID, 0);
      chk({tag, "_last"}, oLAST, 0);
      chk({tag, "_busy"}, oBUSY, 0);
      chk({tag, "_done"}, oDONE, 0);
      chk({tag, "_abort"}, oABORT, 0);
   endtask

   initial begin
      int d0, r0, n;
      iRESET = 1'b1;
      iFHT_RDY = 1'b0;
      iSOURCE_DATA = 1'b0;
      iUNLOAD = 1'b0;
      repeat (3) @(posedge iCLK);
      #1;
      check_zero("reset");
      iRESET = 1'b0;
      iFHT_RDY = 1'b1;
      repeat (2) @(posedge iCLK);
      #1;

      // Basic unload, full-rate downstream, set B.
      ready_mode = 0;
      d0 = done_cnt;
      do_unload(1'b1);
      @(negedge iCLK);
      chk("basic_rd_set", oRD_SET, 1);
      chk("basic_busy", oBUSY, 1);
      wait_done(3000, d0);
      chk("basic_first_valid_lat", first_valid_cyc - unload_cyc, RD_LAT + 1);
      chk("basic_stream_span", last_acc_cyc - first_acc_cyc, N - 1);
      chk("basic_done_after_last", done_cyc - last_acc_cyc, 1);
      chk("basic_count", acc_cnt, N);
      chk("basic_queue_empty", exp_q.size(), 0);
      chk("basic_credit", credit_viol, 0);
      chk("basic_idle_busy", oBUSY, 0);

      // Back-pressure, set A, with an ignored restart attempt mid-READ.
      ready_mode = 1;
      d0 = done_cnt;
      do_unload(1'b0);
      repeat (20) @(posedge iCLK);
      #1;
      iSOURCE_DATA = 1'b1;
      iUNLOAD = 1'b1;
      @(posedge iCLK);
      #1;
      iUNLOAD = 1'b0;
      @(negedge iCLK);
      chk("ign_read_busy", oBUSY, 1);
      chk("ign_read_rdset", oRD_SET, 0);
      wait_done(20000, d0);
      chk("bp_count", acc_cnt, N);
      chk("bp_queue_empty", exp_q.size(), 0);
      chk("bp_credit", credit_viol, 0);

      // Start with iFHT_RDY low is ignored.
      ready_mode = 0;
      @(posedge iCLK);
      #1;
      iFHT_RDY = 1'b0;
      r0 = rden_cnt;
      iUNLOAD = 1'b1;
      @(posedge iCLK);
      #1;
      iUNLOAD = 1'b0;
      repeat (5) @(posedge iCLK);
      #1;
      chk("ign_rdy_rden", rden_cnt - r0, 0);
      chk("ign_rdy_busy", oBUSY, 0);
      iFHT_RDY = 1'b1;

      // Abort after 100 accepted points.
      d0 = done_cnt;
      do_unload(1'b1);
      n = 0;
      while (acc_cnt < 100 && n < 2000) begin
         @(posedge iCLK);
         #1;
         n++;
      end
      chk("abort_reached_100", acc_cnt >= 100, 1);
      iFHT_RDY = 1'b0;
      @(posedge iCLK);
      #1;
      exp_q.delete();
      epoch++;
      @(negedge iCLK);
      chk("abort_busy", oBUSY, 0);
      chk("abort_valid", oVALID, 0);
      chk("abort_flag", oABORT, 1);
      repeat (10) @(posedge iCLK);
      #1;
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_sticky", oABORT, 1);
      iFHT_RDY = 1'b1;
      @(posedge iCLK);
      #1;

      // Restart after abort clears the flag and streams from index 0.
      d0 = done_cnt;
      do_unload(1'b1);
      @(negedge iCLK);
      chk("restart_abort_clr", oABORT, 0);
      wait_done(3000, d0);
      chk("restart_count", acc_cnt, N);
      chk("restart_credit", credit_viol, 0);

      // Asynchronous reset mid-READ.
      do_unload(1'b1);
      repeat (10) @(posedge iCLK);
      #1;
      chk("pre_reset_busy", oBUSY, 1);
      #2;
      iRESET = 1'b1;
      #1;
      check_zero("areset");
      exp_q.delete();
      epoch++;
      @(negedge iCLK);
      #1;
      iRESET = 1'b0;
      repeat (3) @(posedge iCLK);
      #1;
      chk("post_reset_busy", oBUSY, 0);
      chk("post_reset_valid", oVALID, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
